// File: rtl/guess_pkg.sv
// Shared types and LFSR tap definitions for the guessing-game controller.
package guess_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

    localparam logic [3:0] TAPS4 = 4'b1100;
    localparam logic [7:0] TAPS8 = 8'b1011_1000;

    // Tap mask right-aligned in 8 bits; only WIDTH 4 and 8 are meaningful.
    function automatic logic [7:0] tap_mask(input int width);
        return (width == 8) ? TAPS8 : {4'b0000, TAPS4};
    endfunction

endpackage

// File: rtl/dff.sv
// Plain D flip-flop cell; any reset behaviour is muxed in front of d by the user.
module dff (
    input  logic clk,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        q <= d;
    end

endmodule

// File: rtl/lfsr_rng.sv
// Free-running Fibonacci LFSR (left shift) built from individual dff cells.
module lfsr_rng
    import guess_pkg::*;
#(
    parameter int          WIDTH = 4,
    parameter int unsigned SEED  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] q
);

    localparam logic [7:0]       MASK   = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);

    logic             fb;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] d_next;

    assign fb      = ^(q & MASK[WIDTH-1:0]);
    assign shifted = {q[WIDTH-2:0], fb};
    // Synchronous reset is realised as a mux ahead of the cells.
    assign d_next  = rst_n ? shifted : SEED_V;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            dff u_dff (
                .clk (clk),
                .d   (d_next[gi]),
                .q   (q[gi])
            );
        end
    endgenerate

endmodule

// File: rtl/guess_game_ctrl.sv
// Guessing-game sequencer: latches a random target on start, grades guesses,
// and ends in WIN or LOSE. All outputs are registered.
module guess_game_ctrl
    import guess_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter int          MAX_TRIES = 5,
    parameter int unsigned SEED      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             guess_valid,
    input  logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             result_valid,
    output logic             hint_hi,
    output logic             hint_lo,
    output logic             win,
    output logic             lose,
    output logic [3:0]       tries_left
);

    localparam logic [3:0] TRIES_INIT = 4'(MAX_TRIES);

    state_t           state_reg;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] target_reg;
    logic [3:0]       tries_reg;
    logic             busy_reg, result_valid_reg, hint_hi_reg, hint_lo_reg, win_reg, lose_reg;

    lfsr_rng #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            target_reg       <= '0;
            tries_reg        <= '0;
            busy_reg         <= 1'b0;
            result_valid_reg <= 1'b0;
            hint_hi_reg      <= 1'b0;
            hint_lo_reg      <= 1'b0;
            win_reg          <= 1'b0;
            lose_reg         <= 1'b0;
        end else begin
            result_valid_reg <= 1'b0;
            case (state_reg)
                // A new game can start from any idle or finished state.
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        state_reg   <= PLAY;
                        target_reg  <= lfsr_q;
                        tries_reg   <= TRIES_INIT;
                        busy_reg    <= 1'b1;
                        win_reg     <= 1'b0;
                        lose_reg    <= 1'b0;
                        hint_hi_reg <= 1'b0;
                        hint_lo_reg <= 1'b0;
                    end
                end
                PLAY: begin
                    if (guess_valid) begin
                        result_valid_reg <= 1'b1;
                        hint_hi_reg      <= (guess > target_reg);
                        hint_lo_reg      <= (guess < target_reg);
                        tries_reg        <= tries_reg - 4'd1;
                        // A correct guess wins even when it is the last try.
                        if (guess == target_reg) begin
                            state_reg <= WIN;
                            busy_reg  <= 1'b0;
                            win_reg   <= 1'b1;
                        end else if (tries_reg == 4'd1) begin
                            state_reg <= LOSE;
                            busy_reg  <= 1'b0;
                            lose_reg  <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy         = busy_reg;
    assign result_valid = result_valid_reg;
    assign hint_hi      = hint_hi_reg;
    assign hint_lo      = hint_lo_reg;
    assign win          = win_reg;
    assign lose         = lose_reg;
    assign tries_left   = tries_reg;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed bench for guess_game_ctrl (WIDTH=4, MAX_TRIES=5, SEED=1).
module tb_guess_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       guess_valid = 1'b0;
    logic [3:0] guess = 4'd0;
    logic       busy, result_valid, hint_hi, hint_lo, win, lose;
    logic [3:0] tries_left;

    int checks = 0;
    int errors = 0;

    logic [3:0] m_lfsr = 4'd1;
    logic [3:0] exp_target;

    guess_game_ctrl #(
        .WIDTH     (4),
        .MAX_TRIES (5),
        .SEED      (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .guess_valid  (guess_valid),
        .guess        (guess),
        .busy         (busy),
        .result_valid (result_valid),
        .hint_hi      (hint_hi),
        .hint_lo      (hint_lo),
        .win          (win),
        .lose         (lose),
        .tries_left   (tries_left)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^4 + x^3 + 1 taps, shifted left, same reset value.
    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= 4'd1;
        else        m_lfsr <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; guess_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_guess(input logic [3:0] g);
        guess = g; guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".rv"}, result_valid, 0);
        check({tag, ".hi"}, hint_hi, 0);
        check({tag, ".lo"}, hint_lo, 0);
        check({tag, ".win"}, win, 0);
        check({tag, ".lose"}, lose, 0);
        check({tag, ".tries"}, tries_left, 0);
    endtask

    initial begin
        tick();
        do_reset();
        check_zero("reset");

        // Basic game, target = SEED = 1.
        do_start();
        check("start.busy", busy, 1);
        check("start.tries", tries_left, 5);
        do_guess(4'd8);
        check("g8.rv", result_valid, 1);
        check("g8.hi", hint_hi, 1);
        check("g8.lo", hint_lo, 0);
        check("g8.tries", tries_left, 4);
        tick();
        check("idle.rv", result_valid, 0);
        check("hold.hi", hint_hi, 1);
        do_guess(4'd0);
        check("g0.hi", hint_hi, 0);
        check("g0.lo", hint_lo, 1);
        check("g0.tries", tries_left, 3);
        do_guess(4'd1);
        check("g1.win", win, 1);
        check("g1.hi", hint_hi, 0);
        check("g1.lo", hint_lo, 0);
        check("g1.tries", tries_left, 2);
        check("g1.busy", busy, 0);

        // Five consecutive wrong guesses -> LOSE.
        do_reset();
        do_start();
        guess_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            guess = 4'(i + 2);
            tick();
            check($sformatf("b2b%0d.rv", i), result_valid, 1);
            check($sformatf("b2b%0d.tries", i), tries_left, 4 - i);
            check($sformatf("b2b%0d.lose", i), lose, (i == 4) ? 1 : 0);
        end
        guess_valid = 1'b0;
        check("lose.busy", busy, 0);
        do_guess(4'd1);
        check("lose.ign.rv", result_valid, 0);
        check("lose.ign.win", win, 0);
        check("lose.ign.tries", tries_left, 0);

        // Restart from LOSE: new target is the LFSR value on the start edge.
        exp_target = m_lfsr;
        do_start();
        check("restart.busy", busy, 1);
        check("restart.lose", lose, 0);
        check("restart.tries", tries_left, 5);
        check("restart.hi", hint_hi, 0);
        check("restart.lo", hint_lo, 0);
        do_guess(exp_target);
        check("restart.win", win, 1);

        // Correct guess on the last try wins.
        do_reset();
        do_start();
        for (int i = 2; i <= 5; i++) do_guess(4'(i));
        check("last.tries_pre", tries_left, 1);
        do_guess(4'd1);
        check("last.win", win, 1);
        check("last.lose", lose, 0);
        check("last.tries", tries_left, 0);

        // Reset mid-game, then IDLE for 3 edges before start -> target 9.
        do_reset();
        do_start();
        do_guess(4'd2);
        do_guess(4'd3);
        check("mid.tries", tries_left, 3);
        do_reset();
        check_zero("midrst");
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("idle%0d.busy", i), busy, 0);
        end
        do_start();
        do_guess(4'd8);
        check("t9.g8.lo", hint_lo, 1);
        do_guess(4'd10);
        check("t9.g10.hi", hint_hi, 1);
        do_guess(4'd9);
        check("t9.win", win, 1);

        // start alongside a guess in PLAY: guess graded, target kept.
        do_reset();
        do_start();
        start = 1'b1; guess = 4'd2; guess_valid = 1'b1;
        tick();
        start = 1'b0; guess_valid = 1'b0;
        check("sg.rv", result_valid, 1);
        check("sg.hi", hint_hi, 1);
        check("sg.tries", tries_left, 4);
        check("sg.busy", busy, 1);
        do_guess(4'd1);
        check("sg.win", win, 1);
        check("sg.tries2", tries_left, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
